// File: rtl/harmonic_sequencer_pkg.sv
// rtl/harmonic_sequencer_pkg.sv - shared states and constants for the harmonic sequencer and its adder
package harmonic_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADDR,
        S_LUT,
        S_START,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    // Fractional bits of the amplitude; the scaled-sample adder uses the same value
    localparam int DIVISOR_BITS = 9;
    localparam int AMP_UNITY    = (1 << DIVISOR_BITS) - 1;

    // A harmonic increment at or above 2^NYQUIST_BIT would alias
    localparam int NYQUIST_BIT  = 31;

endpackage

// File: rtl/harmonic_phase_gen.sv
// rtl/harmonic_phase_gen.sv - fundamental and per-harmonic phase accumulators
module harmonic_phase_gen #(
    parameter int LUT_ADDR_BITS = 11
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Load,
    input  logic                     i_Step,
    input  logic [31:0]              i_Freq_Inc,
    output logic [LUT_ADDR_BITS-1:0] o_Lut_Addr,
    output logic                     o_Nyquist
);
    import harmonic_sequencer_pkg::*;

    logic [31:0] r_p;
    logic [31:0] r_h_phase;
    logic [32:0] r_h_inc;
    logic [31:0] w_p_next;

    assign w_p_next   = r_p + i_Freq_Inc;
    assign o_Lut_Addr = r_h_phase[31 -: LUT_ADDR_BITS];
    // Bit 32 is the sticky overflow of the harmonic increment, so it also counts as past Nyquist
    assign o_Nyquist  = |r_h_inc[32:NYQUIST_BIT];

    // Load starts a new sample at harmonic 1; step advances to the next harmonic
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_p       <= 32'd0;
            r_h_phase <= 32'd0;
            r_h_inc   <= 33'd0;
        end else if (i_Load) begin
            r_p       <= w_p_next;
            r_h_phase <= w_p_next;
            r_h_inc   <= {1'b0, i_Freq_Inc};
        end else if (i_Step) begin
            r_h_phase <= r_h_phase + r_p;
            if (!r_h_inc[32]) begin
                r_h_inc <= {1'b0, r_h_inc[31:0]} + {1'b0, i_Freq_Inc};
            end
        end
    end

endmodule

// File: rtl/harmonic_sequencer.sv
// rtl/harmonic_sequencer.sv - walks the harmonics of each output sample and feeds the scaled-sample adder
module harmonic_sequencer #(
    parameter int HARMONICS     = 64,
    parameter int LUT_ADDR_BITS = 11,
    parameter int DIVISOR_BITS  = harmonic_sequencer_pkg::DIVISOR_BITS
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Sample_Tick,
    input  logic [31:0]              i_Freq_Inc,
    input  logic [15:0]              i_Harm_Scale,
    output logic [LUT_ADDR_BITS-1:0] o_Lut_Addr,
    input  logic [15:0]              i_Lut_Data,
    output logic                     o_Clear_Accumulator,
    output logic                     o_Start,
    output logic [15:0]              o_Multiple,
    output logic [15:0]              o_Sample,
    input  logic                     i_Adder_Done,
    output logic                     o_Sample_Ready,
    output logic                     o_Busy,
    output logic                     o_Overrun
);
    import harmonic_sequencer_pkg::*;

    localparam logic [7:0]  LAST_HARMONIC = 8'(HARMONICS);
    localparam logic [15:0] AMP_START     = 16'((1 << DIVISOR_BITS) - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_load;
    logic                     w_step;
    logic                     w_nyquist;
    logic                     w_stop;
    logic [LUT_ADDR_BITS-1:0] w_lut_addr;

    logic [15:0]              r_amp;
    logic [7:0]               r_n;
    logic                     r_busy;
    logic                     r_start;
    logic                     r_overrun;
    logic [LUT_ADDR_BITS-1:0] r_lut_addr;
    logic [15:0]              r_sample;
    logic [15:0]              r_multiple;

    harmonic_phase_gen #(
        .LUT_ADDR_BITS (LUT_ADDR_BITS)
    ) u_phase_gen (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Load     (w_load),
        .i_Step     (w_step),
        .i_Freq_Inc (i_Freq_Inc),
        .o_Lut_Addr (w_lut_addr),
        .o_Nyquist  (w_nyquist)
    );

    // A harmonic is skipped (and the sample finished) once it aliases or its amplitude decays away
    assign w_stop = w_nyquist || (r_amp == 16'd0);

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and phase-generator controls
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Sample_Tick) begin
                    w_load       = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: w_state_next = S_ADDR;
            S_ADDR:  w_state_next = w_stop ? S_DONE : S_LUT;
            S_LUT:   w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT: begin
                // r_start is high only in the first WAIT cycle, where the adder's Done is still stale
                if (!r_start && i_Adder_Done) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_step       = 1'b1;
                w_state_next = (r_n == LAST_HARMONIC) ? S_DONE : S_ADDR;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Harmonic counter, amplitude decay and registered adder/LUT outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_amp      <= 16'd0;
            r_n        <= 8'd0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_overrun  <= 1'b0;
            r_lut_addr <= '0;
            r_sample   <= 16'd0;
            r_multiple <= 16'd0;
        end else begin
            r_start   <= (r_state == S_START);
            r_overrun <= i_Sample_Tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_Sample_Tick) begin
                        r_amp  <= AMP_START;
                        r_n    <= 8'd1;
                        r_busy <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (!w_stop) begin
                        r_lut_addr <= w_lut_addr;
                    end
                end
                S_START: begin
                    r_sample   <= i_Lut_Data;
                    r_multiple <= r_amp;
                end
                S_NEXT: begin
                    r_n   <= r_n + 8'd1;
                    r_amp <= 16'(({16'd0, r_amp} * {16'd0, i_Harm_Scale}) >> DIVISOR_BITS);
                end
                S_DONE: r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_Lut_Addr          = r_lut_addr;
    assign o_Clear_Accumulator = (r_state == S_CLEAR);
    assign o_Start             = r_start;
    assign o_Multiple          = r_multiple;
    assign o_Sample            = r_sample;
    assign o_Sample_Ready      = (r_state == S_DONE);
    assign o_Busy              = r_busy;
    assign o_Overrun           = r_overrun;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb/tb_harmonic_sequencer.sv - randomized self-checking bench for harmonic_sequencer
module tb_harmonic_sequencer;

    localparam int HARMONICS     = 64;
    localparam int LUT_ADDR_BITS = 11;
    localparam int DIVISOR_BITS  = 9;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     tick = 1'b0;
    logic [31:0]              freq = 32'd0;
    logic [15:0]              scale = 16'd0;
    logic [LUT_ADDR_BITS-1:0] lut_addr;
    logic [15:0]              lut_data = 16'd0;
    logic                     clr;
    logic                     start;
    logic [15:0]              mult;
    logic [15:0]              samp;
    logic                     adder_done;
    logic                     ready;
    logic                     busy;
    logic                     ovr;

    always #5 clk = ~clk;

    harmonic_sequencer #(
        .HARMONICS     (HARMONICS),
        .LUT_ADDR_BITS (LUT_ADDR_BITS),
        .DIVISOR_BITS  (DIVISOR_BITS)
    ) dut (
        .i_Clock             (clk),
        .i_Reset             (rst),
        .i_Sample_Tick       (tick),
        .i_Freq_Inc          (freq),
        .i_Harm_Scale        (scale),
        .o_Lut_Addr          (lut_addr),
        .i_Lut_Data          (lut_data),
        .o_Clear_Accumulator (clr),
        .o_Start             (start),
        .o_Multiple          (mult),
        .o_Sample            (samp),
        .i_Adder_Done        (adder_done),
        .o_Sample_Ready      (ready),
        .o_Busy              (busy),
        .o_Overrun           (ovr)
    );

    // Sine LUT stand-in: random contents, data one cycle after the address
    logic [15:0] lut_mem [0:(1<<LUT_ADDR_BITS)-1];
    always @(posedge clk) lut_data <= lut_mem[lut_addr];

    // Adder stand-in: Done stays high until it sees Start, then drops for adder_lat cycles
    int adder_lat = 0;
    int adder_cnt = 0;
    always @(posedge clk) begin
        if (rst)             adder_cnt <= 0;
        else if (start)      adder_cnt <= adder_lat;
        else if (adder_cnt > 0) adder_cnt <= adder_cnt - 1;
    end
    assign adder_done = (adder_cnt == 0);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: fundamental phase and the expected harmonic list of one sample
    logic [31:0]              p_model = 32'd0;
    logic [LUT_ADDR_BITS-1:0] e_addr [$];
    logic [15:0]              e_samp [$];
    logic [15:0]              e_mult [$];
    int                       e_lat;

    function automatic void build_expected(input logic [31:0] f, input logic [15:0] sc, input int lat);
        logic [63:0] amp;
        logic [63:0] hinc;
        logic [31:0] ph;
        logic [LUT_ADDR_BITS-1:0] a;
        bit early;
        e_addr.delete();
        e_samp.delete();
        e_mult.delete();
        amp   = 64'd511;
        early = 1'b0;
        for (int n = 1; n <= HARMONICS; n++) begin
            hinc = 64'(n) * 64'(f);
            if (hinc >= 64'h8000_0000 || amp == 64'd0) begin
                early = 1'b1;
                break;
            end
            ph = p_model * 32'(n);
            a  = ph[31 -: LUT_ADDR_BITS];
            e_addr.push_back(a);
            e_samp.push_back(lut_mem[a]);
            e_mult.push_back(amp[15:0]);
            amp = ((amp * 64'(sc)) >> DIVISOR_BITS) & 64'hFFFF;
        end
        // tick cycle, clear, per-harmonic cost, one extra ADDR on early stop, then DONE
        e_lat = 2 + e_addr.size() * (6 + lat) + (early ? 1 : 0);
    endfunction

    task automatic run_sample(input logic [31:0] f, input logic [15:0] sc, input int lat,
                              input int ovr_at, input int rst_after);
        int cyc;
        int n_starts;
        int n_ovr;
        int exp_ovr;
        int n_clr;
        int n_ready;
        bit got_ready;
        bit ovr_pending;
        freq      = f;
        scale     = sc;
        adder_lat = lat;
        p_model   = p_model + f;
        build_expected(f, sc, lat);
        @(negedge clk);
        tick        = 1'b1;
        cyc         = 0;
        n_starts    = 0;
        n_ovr       = 0;
        exp_ovr     = 0;
        n_clr       = 0;
        got_ready   = 1'b0;
        ovr_pending = 1'b0;
        while (!got_ready && cyc < e_lat + 50) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            tick = 1'b0;
            if (ovr) n_ovr++;
            if (ovr_pending) begin
                check("overrun_pulse", ovr, 1);
                ovr_pending = 1'b0;
            end
            if (clr) n_clr++;
            if (cyc == 1) check("busy_after_tick", busy, 1);
            if (start) begin
                check("adder_idle_at_start", adder_cnt == 0, 1);
                if (n_starts < e_addr.size()) begin
                    check("lut_addr", lut_addr, e_addr[n_starts]);
                    check("sample", samp, e_samp[n_starts]);
                    check("multiple", mult, e_mult[n_starts]);
                end
                n_starts++;
                if (n_starts == rst_after) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    check("outputs_after_reset",
                          {lut_addr, clr, start, mult, samp, ready, busy, ovr}, 0);
                    rst     = 1'b0;
                    n_ready = 0;
                    repeat (5) begin
                        @(posedge clk);
                        @(negedge clk);
                        if (ready) n_ready++;
                    end
                    check("no_ready_after_reset", n_ready, 0);
                    p_model = 32'd0;
                    return;
                end
            end
            if (ready) got_ready = 1'b1;
            if (cyc == ovr_at) begin
                tick        = 1'b1;
                ovr_pending = 1'b1;
                exp_ovr++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        if (ovr) n_ovr++;
        if (ovr_pending) check("overrun_pulse", ovr, 1);
        check("ready_seen", got_ready, 1);
        check("ready_latency", cyc, e_lat);
        check("start_count", n_starts, e_addr.size());
        check("clear_count", n_clr, 1);
        check("overrun_count", n_ovr, exp_ovr);
        check("idle_not_busy", busy, 0);
        check("no_accept_after_done", clr, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << LUT_ADDR_BITS); i++) lut_mem[i] = 16'($urandom());
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {lut_addr, clr, start, mult, samp, ready, busy, ovr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full 64 harmonics at unity decay, nominal adder
        run_sample(32'h0100_0000, 16'd512, 0, -1, -1);
        // Nyquist cut after harmonic 3
        run_sample(32'h2000_0000, 16'd512, 0, -1, -1);
        // Halving decay reaches zero amplitude after 9 harmonics
        run_sample(32'h0001_0000 + $urandom_range(0, 32'h00FF_FFFF), 16'd256, 0, -1, -1);
        // Slow adder
        run_sample($urandom_range(0, 32'h01FF_FFFF), 16'($urandom_range(400, 512)), 10, -1, -1);
        // Overrun mid-sample, then overrun in the DONE cycle
        run_sample($urandom_range(0, 32'h01FF_FFFF), 16'd512, 0, 20, -1);
        run_sample(32'h0003_0000, 16'd512, 1, 2 + 64 * 7, -1);
        // Reset during WAIT of harmonic 5, then restart from P=0
        run_sample($urandom_range(1, 32'h01FF_FFFF), 16'd512, 0, -1, 5);
        run_sample($urandom_range(1, 32'h01FF_FFFF), 16'($urandom_range(0, 512)), 0, -1, -1);
        // Zero fundamental: all harmonics on address 0
        run_sample(32'd0, 16'd512, 0, -1, -1);
        // Random mix, including increments already past Nyquist
        for (int k = 0; k < 6; k++) begin
            run_sample($urandom() >> $urandom_range(0, 10), 16'($urandom_range(0, 512)),
                       $urandom_range(0, 3), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
